mem_stage_sram_ctrl: RTL

//   Parametrised MEM pipeline stage with an integrated multi-beat SRAM controller.

---
 rtl/mem_stage_sram_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mem_stage_sram_ctrl.sv
// MEM pipeline stage with a multi-beat controller for an external asynchronous SRAM.
// A DATA_W-bit load/store is split into BEATS transfers of SRAM_DW bits, each
// lasting WAIT_STATES clocks. ready is low while the transfer is in flight so the
// core freezes and ALU_res/val_rm stay stable. SRAM strobes, address and write data
// come straight from flops, so the asynchronous SRAM never sees decode glitches.
module mem_stage_sram_ctrl #(
  parameter int DATA_W      = 32,
  parameter int SRAM_DW     = 16,
  parameter int SRAM_AW     = 18,
  parameter int WAIT_STATES = 4,
  parameter int ADR_OFFSET  = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                MEM_W_EN,
  input  logic                MEM_R_EN,
  input  logic                WB_EN,
  input  logic [3:0]          Dest,
  input  logic [31:0]         ALU_res,
  input  logic [DATA_W-1:0]   val_rm,
  output logic [DATA_W-1:0]   DATA,
  output logic [31:0]         ALU_res_out,
  output logic [3:0]          Dest_out,
  output logic                MEM_R_EN_out,
  output logic                WB_EN_out,
  output logic                ready,
  inout  wire  [SRAM_DW-1:0]  SRAM_DQ,
  output logic [SRAM_AW-1:0]  SRAM_adr,
  output logic                SRAM_UB_N,
  output logic                SRAM_LB_N,
  output logic                SRAM_CE_N,
  output logic                SRAM_WE_N,
  output logic                SRAM_OE_N
);
  localparam int BEATS  = DATA_W / SRAM_DW;
  localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW     = $clog2(WAIT_STATES);
  localparam int WSHIFT = $clog2(DATA_W / 8);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [CW-1:0] LAST_CYC  = CW'(WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state_q, state_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic [CW-1:0]       cyc_q, cyc_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                we_n_q, we_n_d;
  logic                oe_n_q, oe_n_d;
  logic                dq_oe_q, dq_oe_d;
  logic [SRAM_AW-1:0]  adr_q, adr_d;
  logic [SRAM_DW-1:0]  wdat_q, wdat_d;
  logic                req;
  logic [31:0]         word;

  assign req  = MEM_W_EN | MEM_R_EN;
  // Processor word index; a byte address below ADR_OFFSET wraps rather than erroring.
  assign word = (ALU_res - 32'(ADR_OFFSET)) >> WSHIFT;

  // Sequencing: beat/cycle counters, operation latch and load-data assembly.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    cyc_d   = cyc_q;
    wr_d    = wr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = ACCESS;
          beat_d  = '0;
          cyc_d   = '0;
          wr_d    = MEM_W_EN;  // a simultaneous read request is dropped
        end
      end
      ACCESS: begin
        if (cyc_q == LAST_CYC) begin
          cyc_d = '0;
          if (!wr_q) data_d[int'(beat_q)*SRAM_DW +: SRAM_DW] = SRAM_DQ;
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = DONE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // SRAM bus values for the coming cycle, derived from the next state so they can be registered.
  always_comb begin
    we_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    dq_oe_d = 1'b0;
    adr_d   = '0;
    wdat_d  = wdat_q;
    if (state_d == ACCESS) begin
      adr_d = SRAM_AW'(word * 32'(BEATS) + 32'(beat_d));
      if (wr_d) begin
        dq_oe_d = 1'b1;
        we_n_d  = (cyc_d == LAST_CYC);  // last cycle of a beat holds data with WE_N high
        wdat_d  = val_rm[int'(beat_d)*SRAM_DW +: SRAM_DW];
      end else begin
        oe_n_d = 1'b0;
      end
    end
  end

  // State, counters, load data and registered SRAM bus; reset aborts any access at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      cyc_q   <= '0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      we_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      dq_oe_q <= 1'b0;
      adr_q   <= '0;
      wdat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      cyc_q   <= cyc_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
      we_n_q  <= we_n_d;
      oe_n_q  <= oe_n_d;
      dq_oe_q <= dq_oe_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
    end
  end

  assign ready        = ((state_q == IDLE) & ~req) | (state_q == DONE);
  assign WB_EN_out    = WB_EN & ready;
  assign ALU_res_out  = ALU_res;
  assign Dest_out     = Dest;
  assign MEM_R_EN_out = MEM_R_EN;
  assign DATA         = data_q;
  assign SRAM_DQ      = dq_oe_q ? wdat_q : {SRAM_DW{1'bz}};
  assign SRAM_adr     = adr_q;
  assign SRAM_WE_N    = we_n_q;
  assign SRAM_OE_N    = oe_n_q;
  assign SRAM_UB_N    = 1'b0;
  assign SRAM_LB_N    = 1'b0;
  assign SRAM_CE_N    = 1'b0;
endmodule
